// File: rtl/ddr_chk_pkg.sv
// Shared definitions for the DDR read-back stream checker: the end-of-packet
// flag, the header value that is never sequence-checked, the parser states
// and a saturating increment used by every counter in the block.
package ddr_chk_pkg;

   localparam logic [127:0] PKT_END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;
   localparam logic [63:0]  HEAD_SKIP    = 64'h5A5ADEAD_0000FFFF;

   typedef enum logic {
      HEAD    = 1'b0,
      PAYLOAD = 1'b1
   } chk_state_t;

   // Returns val+1, holding at the all-ones value of a wd-bit field (wd <= 64).
   function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned wd);
      logic [63:0] max_val;
      max_val = (wd >= 64) ? {64{1'b1}} : ((64'd1 << wd) - 64'd1);
      sat_inc = (val >= max_val) ? max_val : val + 64'd1;
   endfunction

endpackage

// File: rtl/ddr_stream_nch_chk_if.sv
// Beat stream into the checker. There is no ready: the producer pushes and
// the checker consumes every valid beat.
interface ddr_stream_nch_chk_if #(
   parameter int DATA_WD = 256
);
   logic [DATA_WD-1:0] tdata;
   logic               tvalid;

   modport master (output tdata, output tvalid);
   modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/ddr_sat_cnt.sv
// Saturating event counter with a synchronous clear that beats the increment.
module ddr_sat_cnt
   import ddr_chk_pkg::*;
#(
   parameter int WD = 32
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [WD-1:0] cnt
);

   // Count up on inc, stick at all-ones, clear on clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= WD'(sat_inc(64'(cnt), WD));
   end

endmodule

// File: rtl/ddr_stream_nch_chk.sv
// Packet checker for DDR read-back streams. Each packet is a header beat,
// payload beats and an end-flag beat. Headers carry an incrementing sequence,
// payload lanes carry an incrementing count; both self-synchronise.
// Pipeline: input register -> compare/parse -> counter update.
// Build option DDR_CHK_ERR_CAPTURE_EN adds first-error lane mask / beat index
// capture; without it those outputs are tied to zero.
module ddr_stream_nch_chk
   import ddr_chk_pkg::*;
#(
   parameter int DATA_WD  = 256,
   parameter int HEAD_WD  = 64,
   parameter int LANE_NUM = 8,
   parameter int PKT_LEN  = 0,
   parameter int CNT_WD   = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_rst,
   ddr_stream_nch_chk_if.slave s_axis,
   output logic [CNT_WD-1:0]   adc_suc_cnt,
   output logic [CNT_WD-1:0]   adc_err_cnt,
   output logic [CNT_WD-1:0]   enc_suc_cnt,
   output logic [CNT_WD-1:0]   enc_err_cnt,
   output logic [CNT_WD-1:0]   pkt_cnt,
   output logic [CNT_WD-1:0]   len_err_cnt,
   output logic                err_flag,
   output logic [LANE_NUM-1:0] err_lane_mask,
   output logic [15:0]         err_beat_idx
);

   localparam int LANE_WD   = DATA_WD / LANE_NUM;
   localparam int SLICE_NUM = DATA_WD / 128;
   localparam logic [HEAD_WD-1:0] HEAD_SKIP_W = HEAD_WD'(HEAD_SKIP);

   logic                in_vld;
   logic [DATA_WD-1:0]  in_data;
   logic                is_end;
   logic [HEAD_WD-1:0]  hdr;
   logic [LANE_WD-1:0]  lane0;
   logic [LANE_WD-1:0]  lane_base;
   logic [LANE_NUM-1:0] lane_mask;

   chk_state_t          state, state_nxt;
   logic                hdr_beat, pay_beat, end_beat;

   logic                head_sync;
   logic [HEAD_WD-1:0]  exp_head;
   logic [LANE_WD-1:0]  prev_lane0;
   logic [15:0]         beat_idx;

   logic                s2_enc_suc, s2_enc_err, s2_adc_suc, s2_adc_err, s2_pkt, s2_len_err;

   // Stage 1: register every incoming beat; cfg_rst drops anything arriving with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_vld  <= 1'b0;
         in_data <= '0;
      end else if (cfg_rst) begin
         in_vld  <= 1'b0;
         in_data <= '0;
      end else begin
         in_vld  <= s_axis.tvalid;
         in_data <= s_axis.tdata;
      end
   end

   // Decode the registered beat: end flag, header field and per-lane payload match.
   always_comb begin
      is_end = 1'b0;
      for (int i = 0; i < SLICE_NUM; i++)
         if (in_data[i*128 +: 128] == PKT_END_FLAG)
            is_end = 1'b1;
      hdr       = in_data[HEAD_WD-1:0];
      lane0     = in_data[LANE_WD-1:0];
      lane_base = (beat_idx == 16'd0) ? lane0 : prev_lane0 + LANE_WD'(LANE_NUM);
      lane_mask = '0;
      for (int k = 0; k < LANE_NUM; k++)
         lane_mask[k] = (in_data[k*LANE_WD +: LANE_WD] != lane_base + LANE_WD'(k));
   end

   // Parser state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= HEAD;
      else if (cfg_rst)
         state <= HEAD;
      else
         state <= state_nxt;
   end

   // Classify the beat as header, payload or end and pick the next parser state.
   always_comb begin
      state_nxt = state;
      hdr_beat  = 1'b0;
      pay_beat  = 1'b0;
      end_beat  = 1'b0;
      case (state)
         HEAD: begin
            if (in_vld && !is_end) begin
               hdr_beat  = 1'b1;
               state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (in_vld) begin
               if (is_end) begin
                  end_beat  = 1'b1;
                  state_nxt = HEAD;
               end else begin
                  pay_beat = 1'b1;
               end
            end
         end
         default: state_nxt = HEAD;
      endcase
   end

   // Stage 2: check header sequence and payload lanes, track packet length, emit one-cycle result strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_sync  <= 1'b0;
         exp_head   <= '0;
         prev_lane0 <= '0;
         beat_idx   <= '0;
         s2_enc_suc <= 1'b0;
         s2_enc_err <= 1'b0;
         s2_adc_suc <= 1'b0;
         s2_adc_err <= 1'b0;
         s2_pkt     <= 1'b0;
         s2_len_err <= 1'b0;
      end else if (cfg_rst) begin
         head_sync  <= 1'b0;
         exp_head   <= '0;
         prev_lane0 <= '0;
         beat_idx   <= '0;
         s2_enc_suc <= 1'b0;
         s2_enc_err <= 1'b0;
         s2_adc_suc <= 1'b0;
         s2_adc_err <= 1'b0;
         s2_pkt     <= 1'b0;
         s2_len_err <= 1'b0;
      end else begin
         s2_enc_suc <= 1'b0;
         s2_enc_err <= 1'b0;
         s2_adc_suc <= 1'b0;
         s2_adc_err <= 1'b0;
         s2_pkt     <= 1'b0;
         s2_len_err <= 1'b0;
         if (hdr_beat && (hdr != HEAD_SKIP_W)) begin
            head_sync <= 1'b1;
            exp_head  <= hdr + 1'b1;
            if (!head_sync || (hdr == exp_head))
               s2_enc_suc <= 1'b1;
            else
               s2_enc_err <= 1'b1;
         end
         if (pay_beat) begin
            prev_lane0 <= lane0;
            beat_idx   <= 16'(sat_inc(64'(beat_idx), 16));
            if (|lane_mask)
               s2_adc_err <= 1'b1;
            else
               s2_adc_suc <= 1'b1;
         end
         if (end_beat) begin
            s2_pkt     <= 1'b1;
            s2_len_err <= (PKT_LEN != 0) && (beat_idx != 16'(PKT_LEN));
            beat_idx   <= '0;
         end
      end
   end

   ddr_sat_cnt #(.WD(CNT_WD)) u_adc_suc (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_adc_suc), .cnt(adc_suc_cnt));
   ddr_sat_cnt #(.WD(CNT_WD)) u_adc_err (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_adc_err), .cnt(adc_err_cnt));
   ddr_sat_cnt #(.WD(CNT_WD)) u_enc_suc (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_enc_suc), .cnt(enc_suc_cnt));
   ddr_sat_cnt #(.WD(CNT_WD)) u_enc_err (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_enc_err), .cnt(enc_err_cnt));
   ddr_sat_cnt #(.WD(CNT_WD)) u_pkt     (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_pkt),     .cnt(pkt_cnt));
   ddr_sat_cnt #(.WD(CNT_WD)) u_len_err (.clk(clk), .rst_n(rst_n), .clr(cfg_rst), .inc(s2_len_err), .cnt(len_err_cnt));

   // Stage 3: sticky error flag raised by any payload, header or length error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_flag <= 1'b0;
      else if (cfg_rst)
         err_flag <= 1'b0;
      else if (s2_adc_err || s2_enc_err || s2_len_err)
         err_flag <= 1'b1;
   end

`ifdef DDR_CHK_ERR_CAPTURE_EN
   logic [LANE_NUM-1:0] s2_mask, cap_mask;
   logic [15:0]         s2_idx, cap_idx;
   logic                cap_done;

   // Stage 2: carry the lane mask and packet index of each payload beat next to its result strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_mask <= '0;
         s2_idx  <= '0;
      end else if (cfg_rst) begin
         s2_mask <= '0;
         s2_idx  <= '0;
      end else if (pay_beat) begin
         s2_mask <= lane_mask;
         s2_idx  <= beat_idx;
      end
   end

   // Stage 3: freeze the details of the first failing payload beat only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_done <= 1'b0;
         cap_mask <= '0;
         cap_idx  <= '0;
      end else if (cfg_rst) begin
         cap_done <= 1'b0;
         cap_mask <= '0;
         cap_idx  <= '0;
      end else if (s2_adc_err && !cap_done) begin
         cap_done <= 1'b1;
         cap_mask <= s2_mask;
         cap_idx  <= s2_idx;
      end
   end

   assign err_lane_mask = cap_mask;
   assign err_beat_idx  = cap_idx;
`else
   assign err_lane_mask = '0;
   assign err_beat_idx  = '0;
`endif

endmodule

// File: tb/tb_ddr_stream_nch_chk.sv
// Bench for ddr_stream_nch_chk (8-bit counters, PKT_LEN=4). A behavioural
// model predicts the full output snapshot for every driven beat; a monitor
// compares it three edges after the beat is driven. Each scenario task also
// checks the end totals directly.
module tb_ddr_stream_nch_chk;

   localparam logic [127:0] END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;
   localparam logic [63:0]  SKIP_HDR = 64'h5A5ADEAD_0000FFFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_rst = 1'b0;
   logic [7:0]  adc_suc_cnt, adc_err_cnt, enc_suc_cnt, enc_err_cnt, pkt_cnt, len_err_cnt;
   logic        err_flag;
   logic [7:0]  err_lane_mask;
   logic [15:0] err_beat_idx;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int          due;
      logic [72:0] snap;
   } exp_t;
   exp_t sb_q[$];

   bit          m_pay, m_sync, m_cap;
   logic [63:0] m_exp;
   int          m_idx;
   logic [31:0] m_prev0;
   int          e_adc_suc, e_adc_err, e_enc_suc, e_enc_err, e_pkt, e_len;
   bit          e_err;
   logic [7:0]  e_mask;
   logic [15:0] e_bidx;

   ddr_stream_nch_chk_if #(.DATA_WD(256)) s_if ();

   ddr_stream_nch_chk #(
      .DATA_WD(256), .HEAD_WD(64), .LANE_NUM(8), .PKT_LEN(4), .CNT_WD(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .s_axis(s_if.slave),
      .adc_suc_cnt(adc_suc_cnt), .adc_err_cnt(adc_err_cnt),
      .enc_suc_cnt(enc_suc_cnt), .enc_err_cnt(enc_err_cnt),
      .pkt_cnt(pkt_cnt), .len_err_cnt(len_err_cnt), .err_flag(err_flag),
      .err_lane_mask(err_lane_mask), .err_beat_idx(err_beat_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sat8(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   function automatic logic [72:0] dut_snap();
      return {adc_suc_cnt, adc_err_cnt, enc_suc_cnt, enc_err_cnt, pkt_cnt, len_err_cnt,
              err_flag, err_lane_mask, err_beat_idx};
   endfunction

   function automatic logic [72:0] model_snap();
`ifdef DDR_CHK_ERR_CAPTURE_EN
      return {8'(e_adc_suc), 8'(e_adc_err), 8'(e_enc_suc), 8'(e_enc_err), 8'(e_pkt), 8'(e_len),
              e_err, e_mask, e_bidx};
`else
      return {8'(e_adc_suc), 8'(e_adc_err), 8'(e_enc_suc), 8'(e_enc_err), 8'(e_pkt), 8'(e_len),
              e_err, 8'd0, 16'd0};
`endif
   endfunction

   function automatic void model_reset();
      m_pay = 0; m_sync = 0; m_cap = 0; m_exp = '0; m_idx = 0; m_prev0 = '0;
      e_adc_suc = 0; e_adc_err = 0; e_enc_suc = 0; e_enc_err = 0; e_pkt = 0; e_len = 0;
      e_err = 0; e_mask = '0; e_bidx = '0;
   endfunction

   // Behavioural model of one accepted beat.
   function automatic void model_beat(input logic [255:0] d);
      logic        is_end;
      logic [63:0] hdr;
      logic [31:0] l0, base;
      logic [7:0]  mask;
      is_end = (d[127:0] == END_FLAG) || (d[255:128] == END_FLAG);
      if (!m_pay) begin
         if (!is_end) begin
            m_pay = 1;
            hdr = d[63:0];
            if (hdr != SKIP_HDR) begin
               if (!m_sync || hdr == m_exp) e_enc_suc = sat8(e_enc_suc);
               else begin e_enc_err = sat8(e_enc_err); e_err = 1; end
               m_sync = 1;
               m_exp = hdr + 64'd1;
            end
         end
      end else if (is_end) begin
         e_pkt = sat8(e_pkt);
         if (m_idx != 4) begin e_len = sat8(e_len); e_err = 1; end
         m_idx = 0;
         m_pay = 0;
      end else begin
         l0 = d[31:0];
         base = (m_idx == 0) ? l0 : m_prev0 + 32'd8;
         for (int k = 0; k < 8; k++) mask[k] = (d[k*32 +: 32] != base + 32'(k));
         if (mask != 8'd0) begin
            e_adc_err = sat8(e_adc_err);
            e_err = 1;
            if (!m_cap) begin m_cap = 1; e_mask = mask; e_bidx = 16'(m_idx); end
         end else begin
            e_adc_suc = sat8(e_adc_suc);
         end
         m_prev0 = l0;
         if (m_idx < 65535) m_idx++;
      end
   endfunction

   task automatic send_beat(input logic [255:0] d);
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      model_beat(d);
      sb_q.push_back('{due: cyc + 3, snap: model_snap()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_if.tvalid = 1'b0;
         s_if.tdata  = '0;
      end
   endtask

   // Header, nbeats payload beats from seed 0x100 (optionally one lane flipped), end beat.
   task automatic send_pkt(input logic [63:0] hdr, input int nbeats, input int bad_beat,
                           input int bad_lane, input bit end_hi);
      logic [255:0] w;
      send_beat({192'd0, hdr});
      for (int j = 0; j < nbeats; j++) begin
         for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'h100 + 32'(j*8 + k);
         if (j == bad_beat) w[bad_lane*32 +: 32] = w[bad_lane*32 +: 32] ^ 32'd1;
         send_beat(w);
      end
      send_beat(end_hi ? {END_FLAG, 128'd0} : {128'd0, END_FLAG});
   endtask

   // cfg_rst for one edge, optionally with a beat that must be discarded.
   task automatic pulse_cfg_rst(input bit with_beat, input logic [255:0] d);
      @(negedge clk);
      cfg_rst     = 1'b1;
      s_if.tvalid = with_beat;
      s_if.tdata  = d;
      sb_q.delete();
      model_reset();
      @(negedge clk);
      cfg_rst     = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
   endtask

   task automatic drain(input string name);
      idle(5);
      n_tests++;
      if (sb_q.size() !== 0) begin
         n_fail++;
         $display("[TB] FAIL %s drain: %0d expectations left, want 0", name, sb_q.size());
      end
   endtask

   // Scoreboard monitor: compare the model snapshot once the beat has reached the counters.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_tests++;
            if (dut_snap() !== e.snap) begin
               n_fail++;
               $display("[TB] FAIL snapshot cyc %0d: got %h want %h", cyc, dut_snap(), e.snap);
            end
         end
      end
   end

   task automatic test_reset();
      n_tests++;
      if ({adc_suc_cnt, adc_err_cnt, enc_suc_cnt, enc_err_cnt, pkt_cnt, len_err_cnt} !== 48'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_counters: got %h want 0",
                  {adc_suc_cnt, adc_err_cnt, enc_suc_cnt, enc_err_cnt, pkt_cnt, len_err_cnt});
      end
      n_tests++;
      if (err_flag !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_err_flag: got %b want 0", err_flag);
      end
      n_tests++;
      if ({err_lane_mask, err_beat_idx} !== 24'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_capture: got %h want 0", {err_lane_mask, err_beat_idx});
      end
   endtask

   task automatic test_clean_packets();
      for (int p = 0; p < 10; p++) send_pkt(64'(p), 4, -1, 0, p[0]);
      drain("clean");
      n_tests++;
      if ({enc_suc_cnt, adc_suc_cnt, pkt_cnt} !== {8'd10, 8'd40, 8'd10}) begin
         n_fail++;
         $display("[TB] FAIL clean_totals: got enc %0d adc %0d pkt %0d want 10 40 10",
                  enc_suc_cnt, adc_suc_cnt, pkt_cnt);
      end
      n_tests++;
      if ({adc_err_cnt, enc_err_cnt, len_err_cnt, err_flag} !== 25'd0) begin
         n_fail++;
         $display("[TB] FAIL clean_errors: got %h want 0", {adc_err_cnt, enc_err_cnt, len_err_cnt, err_flag});
      end
   endtask

   task automatic test_header_seq();
      pulse_cfg_rst(1'b0, '0);
      send_pkt(64'd5, 4, -1, 0, 0);
      send_pkt(64'd6, 4, -1, 0, 1);
      send_pkt(SKIP_HDR, 4, -1, 0, 0);
      send_pkt(64'd8, 4, -1, 0, 1);
      send_pkt(64'd9, 4, -1, 0, 0);
      drain("header");
      n_tests++;
      if ({enc_suc_cnt, enc_err_cnt, err_flag} !== {8'd3, 8'd1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL header_seq: got suc %0d err %0d flag %b want 3 1 1",
                  enc_suc_cnt, enc_err_cnt, err_flag);
      end
   endtask

   task automatic test_lane_error();
      pulse_cfg_rst(1'b0, '0);
      send_pkt(64'd0, 4, 2, 3, 0);
      for (int p = 1; p < 10; p++) send_pkt(64'(p), 4, -1, 0, 1);
      drain("lane3");
      n_tests++;
      if ({adc_err_cnt, adc_suc_cnt, err_flag} !== {8'd1, 8'd39, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL lane3_counts: got err %0d suc %0d flag %b want 1 39 1",
                  adc_err_cnt, adc_suc_cnt, err_flag);
      end
`ifdef DDR_CHK_ERR_CAPTURE_EN
      n_tests++;
      if ({err_lane_mask, err_beat_idx} !== {8'h08, 16'd2}) begin
         n_fail++;
         $display("[TB] FAIL lane3_capture: got mask %h idx %0d want 08 2", err_lane_mask, err_beat_idx);
      end
`else
      n_tests++;
      if ({err_lane_mask, err_beat_idx} !== 24'd0) begin
         n_fail++;
         $display("[TB] FAIL lane3_capture_off: got %h want 0", {err_lane_mask, err_beat_idx});
      end
`endif
      // Lane 0 corruption propagates into the next beat's expectation.
      send_pkt(64'd10, 4, 1, 0, 0);
      drain("lane0");
      n_tests++;
      if ({adc_err_cnt, adc_suc_cnt} !== {8'd3, 8'd41}) begin
         n_fail++;
         $display("[TB] FAIL lane0_counts: got err %0d suc %0d want 3 41", adc_err_cnt, adc_suc_cnt);
      end
   endtask

   task automatic test_length();
      pulse_cfg_rst(1'b0, '0);
      send_pkt(64'd0, 3, -1, 0, 0);
      drain("short");
      n_tests++;
      if ({len_err_cnt, pkt_cnt, err_flag} !== {8'd1, 8'd1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL short_pkt: got len %0d pkt %0d flag %b want 1 1 1", len_err_cnt, pkt_cnt, err_flag);
      end
      send_beat({END_FLAG, 128'd0});
      drain("bare_end");
      n_tests++;
      if ({adc_suc_cnt, enc_suc_cnt, pkt_cnt, len_err_cnt} !== {8'd3, 8'd1, 8'd1, 8'd1}) begin
         n_fail++;
         $display("[TB] FAIL bare_end: got %h want 03010101", {adc_suc_cnt, enc_suc_cnt, pkt_cnt, len_err_cnt});
      end
   endtask

   task automatic test_cfg_rst_mid();
      logic [255:0] w;
      pulse_cfg_rst(1'b0, '0);
      send_beat({192'd0, 64'd1});
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'h100 + 32'(j*8 + k);
         send_beat(w);
      end
      pulse_cfg_rst(1'b1, {192'd0, 64'd77});
      n_tests++;
      if (dut_snap() !== 73'd0) begin
         n_fail++;
         $display("[TB] FAIL cfg_rst_clear: got %h want 0", dut_snap());
      end
      idle(3);
      n_tests++;
      if (dut_snap() !== 73'd0) begin
         n_fail++;
         $display("[TB] FAIL cfg_rst_flush: got %h want 0", dut_snap());
      end
      send_pkt(64'd100, 4, -1, 0, 1);
      drain("after_cfg_rst");
      n_tests++;
      if (dut_snap() !== {8'd4, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 1'b0, 24'd0}) begin
         n_fail++;
         $display("[TB] FAIL after_cfg_rst: got %h want enc 1 adc 4 pkt 1 no errors", dut_snap());
      end
   endtask

   task automatic test_saturation();
      pulse_cfg_rst(1'b0, '0);
      send_pkt(64'd3, 260, -1, 0, 0);
      drain("saturation");
      n_tests++;
      if ({adc_suc_cnt, adc_err_cnt, pkt_cnt, len_err_cnt} !== {8'd255, 8'd0, 8'd1, 8'd1}) begin
         n_fail++;
         $display("[TB] FAIL saturation: got suc %0d err %0d pkt %0d len %0d want 255 0 1 1",
                  adc_suc_cnt, adc_err_cnt, pkt_cnt, len_err_cnt);
      end
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_clean_packets();
      test_header_seq();
      test_lane_error();
      test_length();
      test_cfg_rst_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
